// File: rtl/divider_fsm.sv
// Sequential unsigned divider (repeated subtraction) with a shared operand bus.
// Optional zero-divisor flag output enabled by defining DIVIDER_ERR_EN.
module divider_fsm #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done
`ifdef DIVIDER_ERR_EN
  ,
  output logic         div_by_zero
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD_B, SUB, DONE} state_t;

  state_t       state_reg;
  logic [N-1:0] divisor_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      quotient    <= '0;
      remainder   <= '0;
      divisor_reg <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef DIVIDER_ERR_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            remainder <= data_in;
            quotient  <= '0;
            busy      <= 1'b1;
            state_reg <= LOAD_B;
`ifdef DIVIDER_ERR_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
        LOAD_B: begin
          divisor_reg <= data_in;
          state_reg   <= SUB;
        end
        SUB: begin
          // Zero divisor saturates the quotient and leaves the dividend as remainder.
          if (divisor_reg == '0) begin
            quotient  <= '1;
            done      <= 1'b1;
            state_reg <= DONE;
`ifdef DIVIDER_ERR_EN
            div_by_zero <= 1'b1;
`endif
          end else if (remainder >= divisor_reg) begin
            remainder <= remainder - divisor_reg;
            quotient  <= quotient + 1'b1;
          end else begin
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_fsm.sv
// Self-checking bench for divider_fsm: vector table, expected-result queue, reset/abort sequences.
module tb_divider_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] quotient, remainder;
  logic       busy, done;
`ifdef DIVIDER_ERR_EN
  logic       div_by_zero;
`endif

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         q;
    int         r;
    int         lat;
    bit         dbz;
  } vec_t;

  vec_t tbl[9];
  vec_t sb_q[$];

  divider_fsm #(.N(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef DIVIDER_ERR_EN
    ,
    .div_by_zero(div_by_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.a = a;
    v.b = b;
    if (b == 8'd0) begin
      v.q = 255; v.r = a; v.lat = 3; v.dbz = 1'b1;
    end else begin
      v.q = a / b; v.r = a % b; v.lat = a / b + 3; v.dbz = 1'b0;
    end
    return v;
  endfunction

  // Drive one operation; inputs change at negedge so they are stable at posedge.
  task automatic run_op(input vec_t v, input bit poke_start);
    vec_t e;
    int   cyc;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b1;
    data_in = v.a;
    @(negedge clk);
    start = 1'b0;
    data_in = v.b;
    cyc = 1;
    check("busy_c1", busy, 1);
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      data_in = 8'($urandom);
      if (poke_start && !done) start = 1'b1;
      else start = 1'b0;
      if (!done) check("busy_run", busy, 1);
    end
    start = 1'b0;
    e = sb_q.pop_front();
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", cyc, e.lat);
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("busy_at_done", busy, 1);
`ifdef DIVIDER_ERR_EN
      check("div_by_zero", div_by_zero, e.dbz);
`endif
    end
    $display("op %0d / %0d -> q=%0d r=%0d lat=%0d (exp q=%0d r=%0d lat=%0d)",
             e.a, e.b, quotient, remainder, cyc, e.q, e.r, e.lat);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("busy_idle", busy, 0);
    check("q_hold", quotient, e.q);
    check("r_hold", remainder, e.r);
  endtask

  initial begin
    // Hand-derived expectations for the named cases, model for the random ones.
    tbl[0] = '{a: 8'd100, b: 8'd7,  q: 14,  r: 2,  lat: 17,  dbz: 1'b0};
    tbl[1] = '{a: 8'd5,   b: 8'd9,  q: 0,   r: 5,  lat: 3,   dbz: 1'b0};
    tbl[2] = '{a: 8'd255, b: 8'd1,  q: 255, r: 0,  lat: 258, dbz: 1'b0};
    tbl[3] = '{a: 8'd42,  b: 8'd0,  q: 255, r: 42, lat: 3,   dbz: 1'b1};
    tbl[4] = '{a: 8'd9,   b: 8'd9,  q: 1,   r: 0,  lat: 4,   dbz: 1'b0};
    for (int i = 5; i < 9; i++) tbl[i] = model(8'($urandom), 8'($urandom_range(1, 40)));

    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef DIVIDER_ERR_EN
    check("rst_dbz", div_by_zero, 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_op(tbl[i], 1'b0);

    // Back-to-back: new start accepted right after done, zero-flag cleared.
    run_op(model(8'd0, 8'd3), 1'b0);

    // Abort 100/7 with reset during cycle 6 after start.
    @(negedge clk);
    start = 1'b1;
    data_in = 8'd100;
    @(negedge clk);
    start = 1'b0;
    data_in = 8'd7;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done", seen, 0);
    end
    $display("abort 100/7 at cycle 6 -> q=%0d r=%0d", quotient, remainder);

    // Start pulses while busy must not restart the operation.
    run_op(model(8'd9, 8'd3), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
